// File: rtl/des_pkg.sv
// ---------------------------------------------------------------------------
// des_pkg
//   Constants and helpers shared by the DES key schedule, the round datapath
//   and the S-box stage.
//   Contents:
//     KEY_W / HALF_W / CD_W / SUBKEY_W  fixed DES widths
//     PC1, PC2                          permutation tables, 1-based, bit 1 = MSB
//     SHIFT, RSHIFT                     per-round rotate amounts (index 0..15)
//     ks_state_t                        key schedule FSM states
//     rotl28 / rotr28                   28-bit half rotations by 0..2
// ---------------------------------------------------------------------------
package des_pkg;

    localparam int KEY_W    = 64;
    localparam int HALF_W   = 28;
    localparam int CD_W     = 56;
    localparam int SUBKEY_W = 48;

    // Output bit i (0 = MSB) of PC-1 takes key bit PC1[i] (1 = MSB).
    localparam int PC1 [CD_W] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    // Output bit i (0 = MSB) of PC-2 takes CD bit PC2[i] (1 = MSB).
    localparam int PC2 [SUBKEY_W] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    localparam logic [1:0] SHIFT [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    // Right-rotate amounts that walk C16,D16 back down to C1,D1.
    localparam logic [1:0] RSHIFT [16] = '{
        2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ks_state_t;

    function automatic logic [HALF_W-1:0] rotl28(input logic [HALF_W-1:0] x,
                                                 input logic [1:0]        n);
        case (n)
            2'd1:    return {x[HALF_W-2:0], x[HALF_W-1]};
            2'd2:    return {x[HALF_W-3:0], x[HALF_W-1:HALF_W-2]};
            default: return x;
        endcase
    endfunction

    function automatic logic [HALF_W-1:0] rotr28(input logic [HALF_W-1:0] x,
                                                 input logic [1:0]        n);
        case (n)
            2'd1:    return {x[0], x[HALF_W-1:1]};
            2'd2:    return {x[1:0], x[HALF_W-1:2]};
            default: return x;
        endcase
    endfunction

endpackage

// File: rtl/des_pc2.sv
// ---------------------------------------------------------------------------
// des_pc2
//   Combinational DES Permuted Choice 2: selects 48 of the 56 C,D bits.
//   Ports:
//     i_cd      in  56  {C,D}, bit 1 = i_cd[55]
//     o_subkey  out 48  round subkey, bit 1 = o_subkey[47]
// ---------------------------------------------------------------------------
module des_pc2
    import des_pkg::*;
(
    input  logic [CD_W-1:0]     i_cd,
    output logic [SUBKEY_W-1:0] o_subkey
);

    for (genvar i = 0; i < SUBKEY_W; i++) begin : g_pc2
        assign o_subkey[SUBKEY_W-1-i] = i_cd[CD_W-PC2[i]];
    end

endmodule

// File: rtl/des_key_schedule.sv
// ---------------------------------------------------------------------------
// des_key_schedule
//   Produces the 16 DES round subkeys one per valid/ready transfer, in
//   K1..K16 order for encryption or K16..K1 for decryption, from C/D
//   registers rotated in place each round.
//   Ports:
//     clk, rst       clock, synchronous active-high reset
//     key_in   [64]  DES key, parity bits ignored
//     decrypt        direction, captured with start
//     start          begin a schedule (accepted only while ready)
//     ready          idle and able to accept start
//     subkey   [48]  PC-2 of the current C,D
//     subkey_valid   subkey is presented
//     subkey_ready   consumer takes the subkey
//     round    [4]   issue-order index of the presented subkey
//     done           one-cycle pulse after the 16th transfer
// ---------------------------------------------------------------------------
module des_key_schedule
    import des_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [KEY_W-1:0]    key_in,
    input  logic                decrypt,
    input  logic                start,
    output logic                ready,
    output logic [SUBKEY_W-1:0] subkey,
    output logic                subkey_valid,
    input  logic                subkey_ready,
    output logic [3:0]          round,
    output logic                done
);

    ks_state_t         r_state;
    logic [HALF_W-1:0] r_c;
    logic [HALF_W-1:0] r_d;
    logic [3:0]        r_round;
    logic              r_dir;
    logic              r_ready;
    logic              r_valid;
    logic              r_done;

    logic [CD_W-1:0]   w_pc1;
    logic [3:0]        w_next_round;
    logic [1:0]        w_lshift;
    logic [1:0]        w_rshift;

    // PC-1 drops the eight parity bits and reorders the rest into {C0,D0}.
    for (genvar i = 0; i < CD_W; i++) begin : g_pc1
        assign w_pc1[CD_W-1-i] = key_in[KEY_W-PC1[i]];
    end

    assign w_next_round = r_round + 4'd1;
    assign w_lshift     = SHIFT[w_next_round];
    assign w_rshift     = RSHIFT[w_next_round];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_c     <= '0;
            r_d     <= '0;
            r_round <= 4'd0;
            r_dir   <= 1'b0;
            r_ready <= 1'b1;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        // Decrypt starts from C0,D0, which equals C16,D16
                        // because the encrypt rotations sum to 28.
                        if (decrypt) begin
                            r_c <= w_pc1[CD_W-1:HALF_W];
                            r_d <= w_pc1[HALF_W-1:0];
                        end else begin
                            r_c <= rotl28(w_pc1[CD_W-1:HALF_W], 2'd1);
                            r_d <= rotl28(w_pc1[HALF_W-1:0], 2'd1);
                        end
                        r_dir   <= decrypt;
                        r_round <= 4'd0;
                        r_ready <= 1'b0;
                        r_valid <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (subkey_ready) begin
                        if (r_round == 4'd15) begin
                            r_valid <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_round <= w_next_round;
                            if (r_dir) begin
                                r_c <= rotr28(r_c, w_rshift);
                                r_d <= rotr28(r_d, w_rshift);
                            end else begin
                                r_c <= rotl28(r_c, w_lshift);
                                r_d <= rotl28(r_d, w_lshift);
                            end
                        end
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
                default: begin
                    r_valid <= 1'b0;
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    des_pc2 u_pc2 (
        .i_cd     ({r_c, r_d}),
        .o_subkey (subkey)
    );

    assign ready        = r_ready;
    assign subkey_valid = r_valid;
    assign round        = r_round;
    assign done         = r_done;

endmodule

// File: tb/tb_des_key_schedule.sv
// ---------------------------------------------------------------------------
// tb_des_key_schedule
//   Directed bench for des_key_schedule with a scoreboard of expected
//   subkeys produced by a straightforward software key schedule.
// ---------------------------------------------------------------------------
module tb_des_key_schedule;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] key_in;
    logic        decrypt;
    logic        start;
    logic        ready;
    logic [47:0] subkey;
    logic        subkey_valid;
    logic        subkey_ready;
    logic [3:0]  round;
    logic        done;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [47:0] k;
        logic [3:0]  r;
    } exp_t;
    exp_t q[$];

    localparam logic [63:0] KEY1 = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY1_PAR = 64'h123557799BBCDFF0;

    des_key_schedule dut (
        .clk          (clk),
        .rst          (rst),
        .key_in       (key_in),
        .decrypt      (decrypt),
        .start        (start),
        .ready        (ready),
        .subkey       (subkey),
        .subkey_valid (subkey_valid),
        .subkey_ready (subkey_ready),
        .round        (round),
        .done         (done)
    );

    always #5 clk = ~clk;

    // Reference tables (standard DES, 1-based, bit 1 = MSB)
    int m_pc1 [56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,
                       10,2,59,51,43,35,27,19,11,3,60,52,44,36,
                       63,55,47,39,31,23,15,7,62,54,46,38,30,22,
                       14,6,61,53,45,37,29,21,13,5,28,20,12,4};
    int m_pc2 [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,
                       23,19,12,4,26,8,16,7,27,20,13,2,
                       41,52,31,37,47,55,30,40,51,45,33,48,
                       44,49,39,56,34,53,46,42,50,36,29,32};
    int m_ls  [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

    // Subkey Kn (n = 1..16) by cumulative left rotation from C0,D0.
    function automatic logic [47:0] model_k(input logic [63:0] key, input int n);
        logic [55:0] cd;
        logic [27:0] c, d;
        logic [47:0] k;
        for (int i = 0; i < 56; i++) cd[55-i] = key[64-m_pc1[i]];
        c = cd[55:28];
        d = cd[27:0];
        for (int r = 0; r < n; r++) begin
            for (int s = 0; s < m_ls[r]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
        end
        cd = {c, d};
        for (int i = 0; i < 48; i++) k[47-i] = cd[56-m_pc2[i]];
        return k;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in IDLE: issue start for one cycle and queue the expected run.
    task automatic do_start(input logic [63:0] key, input logic dec);
        exp_t e;
        key_in  = key;
        decrypt = dec;
        start   = 1'b1;
        for (int i = 0; i < 16; i++) begin
            e.k = model_k(key, dec ? 16 - i : i + 1);
            e.r = 4'(i);
            q.push_back(e);
        end
        tick();
        start = 1'b0;
        chk("start_latency_valid", 64'(subkey_valid), 64'd1);
        chk("start_ready_low", 64'(ready), 64'd0);
    endtask

    // Consume queued subkeys; mode 0 = always ready, 1 = random with stalls.
    // spam re-asserts start with a junk key/direction throughout the run.
    task automatic drain(input int mode, input bit spam);
        int          cyc = 0;
        int          stall_cnt = 0;
        bit          stalled = 0;
        bit          rdy;
        logic [47:0] hk = '0;
        logic [3:0]  hr = '0;
        exp_t        e;
        while (q.size() > 0 && cyc < 600) begin
            if (subkey_valid) begin
                if (stalled) begin
                    chk("hold_subkey", 64'(subkey), 64'(hk));
                    chk("hold_round", 64'(round), 64'(hr));
                end
                if (mode == 0) rdy = 1'b1;
                else begin
                    if (cyc % 23 == 4) stall_cnt = 10;
                    if (stall_cnt > 0) begin
                        rdy = 1'b0;
                        stall_cnt--;
                    end else rdy = 1'($urandom_range(0, 1));
                end
                subkey_ready = rdy;
                if (rdy) begin
                    e = q.pop_front();
                    chk("subkey", 64'(subkey), 64'(e.k));
                    chk("round", 64'(round), 64'(e.r));
                    stalled = 0;
                end else begin
                    stalled = 1;
                    hk = subkey;
                    hr = round;
                end
            end else begin
                chk("valid_during_run", 64'(subkey_valid), 64'd1);
                subkey_ready = 1'b1;
            end
            if (spam) begin
                start   = 1'b1;
                key_in  = {$urandom, $urandom};
                decrypt = 1'b1;
            end
            tick();
            cyc++;
        end
        if (q.size() > 0) begin
            chk("drain_timeout", 64'(q.size()), 64'd0);
            q.delete();
        end
        // Now in DONE; subkey_ready stays high to show it has no effect.
        subkey_ready = 1'b1;
        chk("done_pulse", 64'(done), 64'd1);
        chk("done_valid_low", 64'(subkey_valid), 64'd0);
        chk("done_ready_low", 64'(ready), 64'd0);
        tick();
        start = 1'b0;
        chk("idle_done_low", 64'(done), 64'd0);
        chk("idle_ready", 64'(ready), 64'd1);
        chk("idle_valid_low", 64'(subkey_valid), 64'd0);
        subkey_ready = 1'b0;
    endtask

    initial begin
        exp_t e;
        rst = 1'b1; key_in = '0; decrypt = 1'b0; start = 1'b1; subkey_ready = 1'b0;
        tick();
        tick();
        // Reset state (start held high together with rst: rst wins)
        chk("rst_ready", 64'(ready), 64'd1);
        chk("rst_valid", 64'(subkey_valid), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_round", 64'(round), 64'd0);
        chk("rst_subkey", 64'(subkey), 64'd0);
        start = 1'b0;
        rst = 1'b0;
        tick();

        // Known-answer constants
        chk("kat_k1", 64'(model_k(KEY1, 1)), 64'h1B02EFFC7072);
        chk("kat_k2", 64'(model_k(KEY1, 2)), 64'h79AED9DBC9E5);
        chk("kat_k15", 64'(model_k(KEY1, 15)), 64'hBF918D3D3F0A);
        chk("kat_k16", 64'(model_k(KEY1, 16)), 64'hCB3D8B0E17F5);

        // 1: encrypt, always ready; first subkey checked against the constant
        do_start(KEY1, 1'b0);
        chk("t1_first", 64'(subkey), 64'h1B02EFFC7072);
        drain(0, 1'b0);

        // 2: decrypt
        do_start(KEY1, 1'b1);
        chk("t2_first", 64'(subkey), 64'hCB3D8B0E17F5);
        drain(0, 1'b0);

        // 3: backpressure, both directions, random keys
        do_start({$urandom, $urandom}, 1'b0);
        drain(1, 1'b0);
        do_start({$urandom, $urandom}, 1'b1);
        drain(1, 1'b0);

        // 4: start spammed during RUN (and into the DONE cycle)
        do_start(KEY1, 1'b0);
        drain(0, 1'b1);
        tick();
        chk("t4_no_restart", 64'(subkey_valid), 64'd0);
        chk("t4_still_ready", 64'(ready), 64'd1);

        // 5: reset at round 7 with a pending transfer
        do_start(KEY1, 1'b0);
        subkey_ready = 1'b1;
        for (int i = 0; i < 40 && round != 4'd7; i++) begin
            e = q.pop_front();
            chk("t5_subkey", 64'(subkey), 64'(e.k));
            tick();
        end
        chk("t5_at_round7", 64'(round), 64'd7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        subkey_ready = 1'b0;
        q.delete();
        chk("t5_valid", 64'(subkey_valid), 64'd0);
        chk("t5_ready", 64'(ready), 64'd1);
        chk("t5_round", 64'(round), 64'd0);
        do_start(KEY1, 1'b0);
        chk("t5_k1", 64'(subkey), 64'h1B02EFFC7072);
        drain(0, 1'b0);

        // 6: parity-bit insensitivity, started right after DONE
        do_start(KEY1_PAR, 1'b0);
        chk("t6_k1", 64'(subkey), 64'h1B02EFFC7072);
        q.delete();
        for (int i = 0; i < 16; i++) begin
            e.k = model_k(KEY1, i + 1);
            e.r = 4'(i);
            q.push_back(e);
        end
        drain(1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule
